// File: rtl/dest_scoreboard_if.sv
// Issue/write-back bus between decode, write-back and the destination scoreboard.
// The master drives the instruction and retire fields; the slave returns the hazard status.
interface dest_scoreboard_if;
    logic        issue_valid;
    logic        issue_wen;
    logic [4:0]  issue_dest;
    logic [4:0]  src_a;
    logic [4:0]  src_b;
    logic        wb_valid;
    logic [4:0]  wb_dest;
    logic        issue_stall;
    logic [31:0] busy;
    logic [6:0]  pending_total;
    logic        err_underflow;

    modport master (
        output issue_valid, issue_wen, issue_dest, src_a, src_b, wb_valid, wb_dest,
        input  issue_stall, busy, pending_total, err_underflow
    );

    modport slave (
        input  issue_valid, issue_wen, issue_dest, src_a, src_b, wb_valid, wb_dest,
        output issue_stall, busy, pending_total, err_underflow
    );
endinterface

// File: rtl/dest_scoreboard.sv
// Destination-register scoreboard: one saturating in-flight counter per architectural
// register, RAW/full stall generation at issue, and retire tracking at write-back.
module dest_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    dest_scoreboard_if.slave  sb
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [31:0] busy;
    logic [31:0] full;
    logic        hz_a;
    logic        hz_b;
    logic        full_d;
    logic        issue_stall;
    logic        accept;
    logic        retire;
    logic        retire_ok;
    logic [6:0]  pending_total_d;
    logic [6:0]  pending_total_q;
    logic        err_underflow_d;
    logic        err_underflow_q;

    // Register 0 is hard-wired and never tracked.
    assign busy[0] = 1'b0;
    assign full[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_reg
            logic [CNT_W-1:0] cnt_d;
            logic [CNT_W-1:0] cnt_q;
            logic             inc;
            logic             dec;

            // Simultaneous issue and retire to the same register cancel out.
            always_comb begin
                inc   = accept && (sb.issue_dest == 5'(gi));
                dec   = retire && (sb.wb_dest == 5'(gi)) && (cnt_q != '0);
                cnt_d = cnt_q;
                if (inc && !dec) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (dec && !inc) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign busy[gi] = (cnt_q != '0);
            assign full[gi] = (cnt_q == CNT_MAX);
        end
    endgenerate

    always_comb begin
        hz_a        = (sb.src_a != 5'd0) && busy[sb.src_a];
        hz_b        = (sb.src_b != 5'd0) && busy[sb.src_b];
        full_d      = sb.issue_wen && (sb.issue_dest != 5'd0) && full[sb.issue_dest];
        issue_stall = sb.issue_valid && (hz_a || hz_b || full_d);
        accept      = sb.issue_valid && !issue_stall && sb.issue_wen && (sb.issue_dest != 5'd0);
        retire      = sb.wb_valid && (sb.wb_dest != 5'd0);
        retire_ok   = retire && busy[sb.wb_dest];

        pending_total_d = pending_total_q;
        if (accept && !retire_ok) begin
            pending_total_d = pending_total_q + 7'd1;
        end else if (retire_ok && !accept) begin
            pending_total_d = pending_total_q - 7'd1;
        end

        err_underflow_d = err_underflow_q || (retire && !busy[sb.wb_dest]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_total_q <= 7'd0;
            err_underflow_q <= 1'b0;
        end else begin
            pending_total_q <= pending_total_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    assign sb.issue_stall   = issue_stall;
    assign sb.busy          = busy;
    assign sb.pending_total = pending_total_q;
    assign sb.err_underflow = err_underflow_q;
endmodule
